// File: rtl/ioctl_upload_spi.sv
// ioctl_upload_spi
// SPI slave on the SS2 channel that streams core memory back to the firmware.
// The host opens a session with START+index. DATA frames then clock bytes out
// on SPI_DO, read through the ioctl_rd/ioctl_addr/ioctl_din port. END closes
// the session. Reads run one byte ahead of the shifter, so the next byte is
// always waiting in tx_buf when the current one finishes.

module ioctl_upload_spi #(
  parameter int ADDR_W     = 25,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              SPI_SCK,
  input  logic              SPI_SS2,
  input  logic              SPI_DI,
  output logic              SPI_DO,
  output logic              spi_do_oe,
  output logic              ioctl_upload,
  output logic [7:0]        ioctl_index,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic              ioctl_rd,
  input  logic [7:0]        ioctl_din
);

  localparam logic [7:0] CMD_START = 8'h60;
  localparam logic [7:0] CMD_DATA  = 8'h61;
  localparam logic [7:0] CMD_END   = 8'h62;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    INDEX,
    DATA,
    SKIP
  } state_t;

  state_t state;

  logic [1:0] sck_sync;
  logic [1:0] ss_sync;
  logic [1:0] di_sync;
  logic       sck_q;
  logic       ss_q;

  logic       sck_rise;
  logic       sck_fall;
  logic       ss_fall;
  logic       ss_high;
  logic       di_bit;

  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte;
  logic [6:0] tx_shift;
  logic [7:0] tx_buf;
  logic       byte_done;
  logic       advance_pending;

  logic [RD_LATENCY-1:0] rd_pipe;

  // Bring the asynchronous SPI pins into clk_sys and keep the previous value for edge detection
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync <= 2'b00;
      ss_sync  <= 2'b11;
      di_sync  <= 2'b00;
      sck_q    <= 1'b0;
      ss_q     <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[0], SPI_SCK};
      ss_sync  <= {ss_sync[0], SPI_SS2};
      di_sync  <= {di_sync[0], SPI_DI};
      sck_q    <= sck_sync[1];
      ss_q     <= ss_sync[1];
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_q;
  assign sck_fall = ~sck_sync[1] & sck_q;
  assign ss_fall  = ~ss_sync[1] & ss_q;
  assign ss_high  = ss_sync[1];
  assign di_bit   = di_sync[1];
  assign rx_byte  = {rx_shift, di_bit};

  // Track each outstanding read for RD_LATENCY cycles and capture its data into tx_buf
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rd_pipe <= '0;
      tx_buf  <= 8'h00;
    end else begin
      rd_pipe <= (rd_pipe << 1) | RD_LATENCY'(ioctl_rd);
      if (rd_pipe[RD_LATENCY-1]) begin
        tx_buf <= ioctl_din;
      end
    end
  end

  // Frame/command state machine, MOSI receiver, MISO shifter and read-ahead address control.
  // The address step and read for a byte are committed on the first rise of that byte rather
  // than on the fall that loads it: the last fall of a frame loads a byte that is never clocked
  // out, and deferring keeps that byte in tx_buf for the next DATA frame.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      SPI_DO          <= 1'b0;
      spi_do_oe       <= 1'b0;
      ioctl_upload    <= 1'b0;
      ioctl_index     <= 8'h00;
      ioctl_addr      <= '0;
      ioctl_rd        <= 1'b0;
      bit_cnt         <= 3'd0;
      rx_shift        <= 7'h00;
      tx_shift        <= 7'h00;
      byte_done       <= 1'b0;
      advance_pending <= 1'b0;
    end else begin
      ioctl_rd <= 1'b0;

      if (ss_high) begin
        state           <= IDLE;
        spi_do_oe       <= 1'b0;
        SPI_DO          <= 1'b0;
        bit_cnt         <= 3'd0;
        rx_shift        <= 7'h00;
        byte_done       <= 1'b0;
        advance_pending <= 1'b0;
      end else if (ss_fall) begin
        state           <= CMD;
        bit_cnt         <= 3'd0;
        rx_shift        <= 7'h00;
        byte_done       <= 1'b0;
        advance_pending <= 1'b0;
      end else if (sck_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= {rx_shift[5:0], di_bit};

        if (advance_pending) begin
          ioctl_addr      <= ioctl_addr + ADDR_W'(1);
          ioctl_rd        <= 1'b1;
          advance_pending <= 1'b0;
        end

        if (bit_cnt == 3'd7) begin
          case (state)
            CMD: begin
              case (rx_byte)
                CMD_START: state <= INDEX;
                CMD_DATA: begin
                  state     <= DATA;
                  spi_do_oe <= ioctl_upload;
                  byte_done <= ioctl_upload;
                end
                CMD_END: begin
                  ioctl_upload <= 1'b0;
                  state        <= SKIP;
                end
                default: state <= SKIP;
              endcase
            end
            INDEX: begin
              ioctl_index  <= rx_byte;
              ioctl_addr   <= '0;
              ioctl_upload <= 1'b1;
              ioctl_rd     <= 1'b1;
              state        <= SKIP;
            end
            DATA: byte_done <= spi_do_oe;
            default: ;
          endcase
        end
      end else if (sck_fall) begin
        if (spi_do_oe) begin
          if (byte_done) begin
            SPI_DO          <= tx_buf[7];
            tx_shift        <= tx_buf[6:0];
            byte_done       <= 1'b0;
            advance_pending <= 1'b1;
          end else begin
            SPI_DO   <= tx_shift[6];
            tx_shift <= {tx_shift[5:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ioctl_upload_spi.sv
// tb_ioctl_upload_spi
// Drives three uploader instances from one SPI host: (a) default widths with
// RD_LATENCY=1, (b) RD_LATENCY=4, (c) ADDR_W=4 for address wrap. Each instance
// has its own memory model returning 0xA0+addr exactly RD_LATENCY cycles after
// a read strobe and 0xEE at any other time.

module tb_ioctl_upload_spi;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic sck     = 1'b0;
  logic ss2     = 1'b1;
  logic di      = 1'b0;

  logic        do_a, oe_a, up_a, rd_a;
  logic [7:0]  idx_a, din_a;
  logic [24:0] addr_a;

  logic        do_b, oe_b, up_b, rd_b;
  logic [7:0]  idx_b, din_b;
  logic [24:0] addr_b;

  logic        do_c, oe_c, up_c, rd_c;
  logic [7:0]  idx_c, din_c;
  logic [3:0]  addr_c;

  logic [7:0] miso_a, miso_b, miso_c;
  int n_compared   = 0;
  int n_mismatched = 0;
  int cnt_a = 0, cnt_b = 0, cnt_c = 0;

  ioctl_upload_spi #(.ADDR_W(25), .RD_LATENCY(1)) dut_a (
    .clk_sys(clk_sys), .reset_n(reset_n), .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_DI(di),
    .SPI_DO(do_a), .spi_do_oe(oe_a), .ioctl_upload(up_a), .ioctl_index(idx_a),
    .ioctl_addr(addr_a), .ioctl_rd(rd_a), .ioctl_din(din_a));

  ioctl_upload_spi #(.ADDR_W(25), .RD_LATENCY(4)) dut_b (
    .clk_sys(clk_sys), .reset_n(reset_n), .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_DI(di),
    .SPI_DO(do_b), .spi_do_oe(oe_b), .ioctl_upload(up_b), .ioctl_index(idx_b),
    .ioctl_addr(addr_b), .ioctl_rd(rd_b), .ioctl_din(din_b));

  ioctl_upload_spi #(.ADDR_W(4), .RD_LATENCY(1)) dut_c (
    .clk_sys(clk_sys), .reset_n(reset_n), .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_DI(di),
    .SPI_DO(do_c), .spi_do_oe(oe_c), .ioctl_upload(up_c), .ioctl_index(idx_c),
    .ioctl_addr(addr_c), .ioctl_rd(rd_c), .ioctl_din(din_c));

  always #5 clk_sys = ~clk_sys;

  // Memory model with one cycle of read latency for instance a
  logic        va = 1'b0;
  logic [24:0] aa = '0;
  always @(posedge clk_sys) begin
    va <= rd_a;
    aa <= addr_a;
  end
  assign din_a = va ? 8'hA0 + aa[7:0] : 8'hEE;

  // Memory model with four cycles of read latency for instance b
  logic [3:0]  vb = 4'h0;
  logic [24:0] ab [4];
  always @(posedge clk_sys) begin
    vb    <= {vb[2:0], rd_b};
    ab[0] <= addr_b;
    for (int i = 1; i < 4; i++) ab[i] <= ab[i-1];
  end
  assign din_b = vb[3] ? 8'hA0 + ab[3][7:0] : 8'hEE;

  // Memory model with a 4-bit address for instance c
  logic       vc = 1'b0;
  logic [3:0] ac = 4'h0;
  always @(posedge clk_sys) begin
    vc <= rd_c;
    ac <= addr_c;
  end
  assign din_c = vc ? 8'hA0 + {4'h0, ac} : 8'hEE;

  // Count read strobes seen by each instance
  always @(posedge clk_sys) begin
    if (rd_a) cnt_a <= cnt_a + 1;
    if (rd_b) cnt_b <= cnt_b + 1;
    if (rd_c) cnt_c <= cnt_c + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Clock nbits of mosi (MSB first, mode 0) with a half-period of 4 clk_sys,
  // sampling each instance's MISO just before every rising edge
  task automatic spi_bits(input logic [7:0] mosi, input int nbits);
    miso_a = 8'h00;
    miso_b = 8'h00;
    miso_c = 8'h00;
    for (int k = 7; k > 7 - nbits; k--) begin
      di = mosi[k];
      repeat (4) @(negedge clk_sys);
      miso_a = {miso_a[6:0], do_a};
      miso_b = {miso_b[6:0], do_b};
      miso_c = {miso_c[6:0], do_c};
      sck = 1'b1;
      repeat (4) @(negedge clk_sys);
      sck = 1'b0;
    end
  endtask

  task automatic ss_low();
    @(negedge clk_sys);
    ss2 = 1'b0;
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic ss_high();
    repeat (4) @(negedge clk_sys);
    ss2 = 1'b1;
    repeat (10) @(negedge clk_sys);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_sys);
    check_output("rst_spi_do", do_a, 0);
    check_output("rst_oe", oe_a, 0);
    check_output("rst_upload", up_a, 0);
    check_output("rst_index", idx_a, 0);
    check_output("rst_addr", addr_a, 0);
    check_output("rst_rd", rd_a, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_sys);

    // START with index 5
    ss_low();
    spi_bits(8'h60, 8);
    spi_bits(8'h05, 8);
    ss_high();
    check_output("start_index_a", idx_a, 8'h05);
    check_output("start_index_b", idx_b, 8'h05);
    check_output("start_upload_a", up_a, 1);
    check_output("start_upload_c", up_c, 1);
    check_output("start_addr_a", addr_a, 0);
    check_output("start_rdcnt_a", cnt_a, 1);

    // DATA frame of four bytes
    ss_low();
    spi_bits(8'h61, 8);
    for (int i = 0; i < 4; i++) begin
      spi_bits(8'h00, 8);
      check_output($sformatf("basic_miso_a%0d", i), miso_a, 8'hA0 + i);
      check_output($sformatf("basic_miso_b%0d", i), miso_b, 8'hA0 + i);
      check_output($sformatf("basic_miso_c%0d", i), miso_c, 8'hA0 + i);
    end
    check_output("basic_oe_in_frame", oe_a, 1);
    ss_high();
    check_output("basic_oe_after", oe_a, 0);
    check_output("basic_addr_a", addr_a, 4);
    check_output("basic_rdcnt_a", cnt_a, 5);
    check_output("basic_rdcnt_b", cnt_b, 5);

    // Second DATA frame continues from address 4
    ss_low();
    spi_bits(8'h61, 8);
    for (int i = 4; i < 6; i++) begin
      spi_bits(8'h00, 8);
      check_output($sformatf("cont_miso_a%0d", i), miso_a, 8'hA0 + i);
      check_output($sformatf("cont_miso_b%0d", i), miso_b, 8'hA0 + i);
    end
    ss_high();
    check_output("cont_addr_a", addr_a, 6);
    check_output("cont_rdcnt_a", cnt_a, 7);

    // Abort after three bits of byte 0xA6 (top bits 101)
    ss_low();
    spi_bits(8'h61, 8);
    spi_bits(8'h00, 3);
    check_output("abort_partial_a", miso_a, 8'h05);
    ss_high();
    check_output("abort_oe_a", oe_a, 0);
    check_output("abort_oe_b", oe_b, 0);
    ss_low();
    spi_bits(8'h61, 8);
    for (int i = 7; i < 9; i++) begin
      spi_bits(8'h00, 8);
      check_output($sformatf("resume_miso_a%0d", i), miso_a, 8'hA0 + i);
      check_output($sformatf("resume_miso_b%0d", i), miso_b, 8'hA0 + i);
    end
    ss_high();
    check_output("resume_addr_a", addr_a, 9);
    check_output("resume_rdcnt_a", cnt_a, 10);

    // END closes the session; DATA afterwards must stay silent
    ss_low();
    spi_bits(8'h62, 8);
    ss_high();
    check_output("end_upload_a", up_a, 0);
    check_output("end_upload_b", up_b, 0);
    ss_low();
    spi_bits(8'h61, 8);
    spi_bits(8'h00, 8);
    check_output("nosess_oe_a", oe_a, 0);
    check_output("nosess_miso_a", miso_a, 8'h00);
    ss_high();
    check_output("nosess_rdcnt_a", cnt_a, 10);
    check_output("nosess_rdcnt_c", cnt_c, 10);

    // New session with index 7, two bytes
    ss_low();
    spi_bits(8'h60, 8);
    spi_bits(8'h07, 8);
    ss_high();
    check_output("restart_index_a", idx_a, 8'h07);
    ss_low();
    spi_bits(8'h61, 8);
    for (int i = 0; i < 2; i++) begin
      spi_bits(8'h00, 8);
      check_output($sformatf("sess2_miso_a%0d", i), miso_a, 8'hA0 + i);
      check_output($sformatf("sess2_miso_b%0d", i), miso_b, 8'hA0 + i);
    end
    ss_high();
    check_output("sess2_addr_a", addr_a, 2);

    // START while open restarts at address 0 with index 9
    ss_low();
    spi_bits(8'h60, 8);
    spi_bits(8'h09, 8);
    ss_high();
    check_output("midstart_index_a", idx_a, 8'h09);
    check_output("midstart_addr_a", addr_a, 0);
    check_output("midstart_upload_a", up_a, 1);

    // Seventeen bytes: instance c wraps from address 15 back to 0
    ss_low();
    spi_bits(8'h61, 8);
    for (int i = 0; i < 17; i++) begin
      spi_bits(8'h00, 8);
      check_output($sformatf("wrap_miso_a%0d", i), miso_a, 8'hA0 + i);
      check_output($sformatf("wrap_miso_b%0d", i), miso_b, 8'hA0 + i);
      check_output($sformatf("wrap_miso_c%0d", i), miso_c, 8'hA0 + (i % 16));
    end
    ss_high();
    check_output("wrap_addr_a", addr_a, 17);
    check_output("wrap_addr_c", addr_c, 1);
    check_output("wrap_rdcnt_a", cnt_a, 31);
    check_output("wrap_rdcnt_c", cnt_c, 31);

    // Asynchronous reset in the middle of a data byte
    ss_low();
    spi_bits(8'h61, 8);
    spi_bits(8'h00, 3);
    check_output("prerst_oe_a", oe_a, 1);
    @(posedge clk_sys);
    #1 reset_n = 1'b0;
    #1;
    check_output("arst_spi_do", do_a, 0);
    check_output("arst_oe", oe_a, 0);
    check_output("arst_upload", up_a, 0);
    check_output("arst_index", idx_a, 0);
    check_output("arst_addr", addr_a, 0);
    check_output("arst_rd", rd_a, 0);
    check_output("arst_addr_c", addr_c, 0);
    @(negedge clk_sys);
    ss2 = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_sys);

    // Fresh session after reset starts cleanly at 0xA0
    ss_low();
    spi_bits(8'h60, 8);
    spi_bits(8'h03, 8);
    ss_high();
    ss_low();
    spi_bits(8'h61, 8);
    spi_bits(8'h00, 8);
    check_output("postrst_miso_a", miso_a, 8'hA0);
    check_output("postrst_miso_b", miso_b, 8'hA0);
    ss_high();
    check_output("postrst_index_a", idx_a, 8'h03);
    check_output("postrst_addr_a", addr_a, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
